// File: rtl/disp_log_pkg.sv
// disp_log_pkg: shared widths, converter FSM states and record type for the display event logger
package disp_log_pkg;
    localparam int DEF_DISP_BITS = 16;
    localparam int DEF_CNT_BITS  = 32;
    localparam int DEF_DEC_DIGS  = 10;
    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
    typedef struct packed {
        logic [DEF_DISP_BITS-1:0]  disp;
        logic [DEF_DEC_DIGS*4-1:0] time_bcd;
    } rec_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per clock
module bin2bcd_seq #(
    parameter int BIN_BITS = 32,
    parameter int DIGS     = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [BIN_BITS-1:0] i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [DIGS*4-1:0]   o_bcd
);
    localparam int CW = $clog2(BIN_BITS);
    localparam int BW = DIGS * 4;
    logic [BIN_BITS-1:0] r_bin;
    logic [BW-1:0]       r_bcd;
    logic [BW-1:0]       w_adj;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    for (genvar d = 0; d < DIGS; d++) begin : g_adj
        assign w_adj[d*4+:4] = (r_bcd[d*4+:4] >= 4'd5) ? r_bcd[d*4+:4] + 4'd3 : r_bcd[d*4+:4];
    end
    // o_done marks the edge on which the final shift happens, so the caller can move on without a bubble
    assign o_done = r_busy && (r_cnt == CW'(BIN_BITS - 1));
    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bin  <= r_bin << 1;
            r_bcd  <= BW'({w_adj, r_bin[BIN_BITS-1]});
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !o_done;
        end
    end
endmodule

// File: rtl/disp_event_logger.sv
// disp_event_logger: time-stamps every change of the display-control word and streams (value, BCD cycle) records
module disp_event_logger
    import disp_log_pkg::*;
#(
    parameter int DISP_BITS  = DEF_DISP_BITS,
    parameter int CNT_BITS   = DEF_CNT_BITS,
    parameter int DEC_DIGS   = DEF_DEC_DIGS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DISP_BITS-1:0]  i_disp_val,
    output logic                  o_rec_valid,
    input  logic                  i_rec_ready,
    output logic [DISP_BITS-1:0]  o_rec_disp,
    output logic [DEC_DIGS*4-1:0] o_rec_time,
    output logic                  o_overflow,
    output logic [7:0]            o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_t               r_state, w_next;
    logic [CNT_BITS-1:0]  r_cycle;
    logic [DISP_BITS-1:0] r_prev, r_disp;
    logic [DISP_BITS-1:0] r_fdisp [FIFO_DEPTH];
    logic [CNT_BITS-1:0]  r_ftime [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_count;
    logic                 r_ovf;
    logic [7:0]           r_drops;
    logic                 w_change, w_push, w_pop, w_busy, w_done;
    // a full FIFO still takes a push when the converter pops on the same edge
    assign w_change = i_disp_val != r_prev;
    assign w_push   = w_change && (r_count != (AW+1)'(FIFO_DEPTH) || w_pop);
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: if (r_count != '0 && !w_busy) begin
                w_pop  = 1'b1;
                w_next = SHIFT;
            end
            SHIFT:   if (w_done) w_next = OUT;
            OUT:     if (i_rec_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fdisp[r_wptr] <= i_disp_val;
            r_ftime[r_wptr] <= r_cycle;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cycle <= '0;
            r_prev  <= '0;
            r_disp  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_drops <= '0;
        end else begin
            r_state <= w_next;
            r_cycle <= &r_cycle ? r_cycle : r_cycle + CNT_BITS'(1);
            r_prev  <= i_disp_val;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_disp <= r_fdisp[r_rptr];
            end
            if (w_change && !w_push) begin
                r_ovf <= 1'b1;
                if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
            end
        end
    end
    bin2bcd_seq #(.BIN_BITS(CNT_BITS), .DIGS(DEC_DIGS)) u_bcd (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_start (w_pop),
        .i_bin   (r_ftime[r_rptr]),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (o_rec_time)
    );
    assign o_rec_valid  = r_state == OUT;
    assign o_rec_disp   = r_disp;
    assign o_overflow   = r_ovf;
    assign o_drop_count = r_drops;
endmodule

// File: tb/tb_disp_event_logger.sv
// tb_disp_event_logger: directed table, corner sequences and randomized scoreboard for disp_event_logger
module tb_disp_event_logger;
    logic        clk = 1'b0, rst = 1'b1, rst_s = 1'b1, ready = 1'b0, ready_s = 1'b1;
    logic [15:0] disp = '0, disp_s = '0;
    logic        valid, ovf, valid_s, ovf_s;
    logic [15:0] rdisp, rdisp_s;
    logic [39:0] rtime;
    logic [11:0] rtime_s;
    logic [7:0]  drops, drops_s;
    int          checks = 0, errors = 0;
    int          cyc;

    disp_event_logger u_dut (
        .i_clk(clk), .i_reset(rst), .i_disp_val(disp), .o_rec_valid(valid), .i_rec_ready(ready),
        .o_rec_disp(rdisp), .o_rec_time(rtime), .o_overflow(ovf), .o_drop_count(drops)
    );
    disp_event_logger #(.CNT_BITS(8), .DEC_DIGS(3)) u_sml (
        .i_clk(clk), .i_reset(rst_s), .i_disp_val(disp_s), .o_rec_valid(valid_s), .i_rec_ready(ready_s),
        .o_rec_disp(rdisp_s), .o_rec_time(rtime_s), .o_overflow(ovf_s), .o_drop_count(drops_s)
    );

    always #5 clk = ~clk;
    // cycle number the next rising edge will stamp
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    typedef struct { int at; logic [15:0] val; logic [39:0] t; } vec_t;
    typedef struct { logic [15:0] d; logic [39:0] t; } exp_t;
    vec_t vecs[5];
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] to_bcd(input longint v);
        logic [39:0] r;
        for (int d = 0; d < 10; d++) begin
            r[d*4+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // k = edges seen including the capture edge when the capture was set up on the previous negedge
    task automatic wait_valid(output int k);
        k = 0;
        while (!valid && k < 80) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k, capt[6], seen;
        logic [15:0] nv;
        vecs[0] = '{1234,  16'h0003, 40'h0000001234};
        vecs[1] = '{1300,  16'hABCD, 40'h0000001300};
        vecs[2] = '{1400,  16'h0000, 40'h0000001400};
        vecs[3] = '{9999,  16'h8001, 40'h0000009999};
        vecs[4] = '{10050, 16'hFFFF, 40'h0000010050};
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_disp", rdisp, 0);
        chk("rst_time", rtime, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drops", drops, 0);
        rst = 1'b0;
        rst_s = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("idle_valid", seen, 0);
        chk("idle_ovf", ovf, 0);
        chk("idle_drops", drops, 0);

        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            while (cyc < vecs[i].at) @(negedge clk);
            disp = vecs[i].val;
            wait_valid(k);
            chk("vec_latency", k - 1, 33);
            chk("vec_disp", rdisp, vecs[i].val);
            chk("vec_time", rtime, vecs[i].t);
            @(negedge clk);
            chk("vec_valid_clr", valid, 0);
        end

        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("drop_ovf_pre", ovf, 0);
            capt[i] = cyc;
            disp = 16'(i + 1);
            @(negedge clk);
        end
        chk("drop_ovf", ovf, 1);
        chk("drop_cnt", drops, 1);
        wait_valid(k);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (!valid || rdisp !== 16'h1 || rtime !== to_bcd(capt[0])) seen = 1;
        end
        chk("hold_stable", seen, 0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(k);
            chk("burst_disp", rdisp, 16'(i + 1));
            chk("burst_time", rtime, to_bcd(capt[i]));
            @(negedge clk);
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("burst_no_6th", seen, 0);

        disp = 16'h0042;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_shift_valid", valid, 0);
        chk("rst_clr_ovf", ovf, 0);
        chk("rst_clr_drops", drops, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(k);
        chk("restart_latency", k - 1, 33);
        chk("restart_disp", rdisp, 16'h0042);
        chk("restart_time", rtime, 0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("restart_single", seen, 0);

        ready = 1'b0;
        disp = 16'h0077;
        @(negedge clk);
        wait_valid(k);
        chk("out_reached", valid, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_out_valid", valid, 0);
        chk("rst_out_disp", rdisp, 0);
        disp = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("no_stale", seen, 0);

        for (int i = 0; i < 20 * 40; i++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            if (i % 40 == 0) begin
                do nv = 16'($urandom); while (nv == disp);
                disp = nv;
                q.push_back('{nv, to_bcd(cyc)});
            end
            if (valid && ready) begin
                if (q.size() == 0) chk("rand_extra", 1, 0);
                else begin
                    chk("rand_disp", rdisp, q[0].d);
                    chk("rand_time", rtime, q[0].t);
                    void'(q.pop_front());
                end
            end
        end
        ready = 1'b1;
        for (int i = 0; i < 300 && q.size() > 0; i++) begin
            @(negedge clk);
            if (valid) begin
                chk("rand_disp", rdisp, q[0].d);
                chk("rand_time", rtime, q[0].t);
                void'(q.pop_front());
            end
        end
        chk("rand_all_out", q.size(), 0);
        chk("rand_drops", drops, 0);

        disp_s = 16'h0005;
        k = 0;
        @(negedge clk);
        while (!valid_s && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("sat_latency", k, 9);
        chk("sat_disp", rdisp_s, 16'h0005);
        chk("sat_time", rtime_s, 12'h255);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
